conv_mac_accumulator: RTL and testbench



---
 rtl/conv_mac_accumulator.sv | 129 ++++++++++++
 tb/tb_conv_mac_accumulator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_accumulator.sv
// conv_mac_accumulator: sequential multiply-accumulate stage of the
// convolutional layer. Accumulates KERNEL_SIZE*KERNEL_SIZE pixel*weight taps
// plus a bias. It then emits one rescaled, saturated, optionally ReLU'd
// feature-map value.
//
// Handshake semantics (both sides, strict valid/ready):
//   - A tap transfers on a rising edge where in_valid & in_ready & ~clear.
//   - A result transfers on a rising edge where out_valid & out_ready.
//   - in_ready and out_valid are pure decodes of the state register. They
//     never depend combinationally on in_valid or out_ready.
//   - Once out_valid is high, out_data is held stable until the transfer.
//   - The block never accepts a tap while a result is pending.
module conv_mac_accumulator #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ACC_WIDTH   = 40,
  localparam int TAPS       = KERNEL_SIZE * KERNEL_SIZE,
  localparam int CNT_WIDTH  = $clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  relu_en,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic [DATA_WIDTH-1:0] wgt_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  tap_cnt
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;
  logic signed [ACC_WIDTH-1:0]    bias_ext;
  logic signed [ACC_WIDTH-1:0]    acc_base;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [ACC_WIDTH-1:0]    acc_shift;
  logic [ACC_WIDTH-DATA_WIDTH:0]  upper_bits;
  logic                           fits;
  logic [DATA_WIDTH-1:0]          sat_value;
  logic [DATA_WIDTH-1:0]          result;
  logic                           accept;
  logic                           first_tap;
  logic                           last_tap;

  // A tap that coincides with clear is dropped.
  assign accept    = in_valid & (state == ACC) & ~clear;
  assign first_tap = (tap_cnt == '0);
  assign last_tap  = (tap_cnt == CNT_WIDTH'(TAPS - 1));

  // Full-precision product and the bias aligned to the product's binary point.
  assign product     = $signed(pix_in) * $signed(wgt_in);
  assign product_ext = {{(ACC_WIDTH-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
  assign bias_ext    = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} <<< FRAC_BITS;
  assign acc_base    = first_tap ? bias_ext : acc;
  assign acc_sum     = acc_base + product_ext;

  // Rescale back to FRAC_BITS. The arithmetic shift truncates toward -inf.
  // The value fits the output width only when every bit from the output
  // sign bit upward is a copy of that sign bit.
  assign acc_shift  = acc_sum >>> FRAC_BITS;
  assign upper_bits = acc_shift[ACC_WIDTH-1:DATA_WIDTH-1];
  assign fits       = (&upper_bits) | ~(|upper_bits);
  assign sat_value  = fits ? acc_shift[DATA_WIDTH-1:0]
                    : (acc_shift[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                              : {1'b0, {(DATA_WIDTH-1){1'b1}}});
  assign result     = (relu_en & sat_value[DATA_WIDTH-1]) ? '0 : sat_value;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode. clear overrides every transition.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (accept && last_tap) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
    if (clear) state_next = ACC;
  end

  // Accumulator, tap counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      tap_cnt  <= '0;
      out_data <= '0;
    end else if (clear) begin
      tap_cnt <= '0;
    end else if (accept) begin
      acc <= acc_sum;
      if (last_tap) begin
        tap_cnt  <= '0;
        out_data <= result;
      end else begin
        tap_cnt <= tap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Testbench for conv_mac_accumulator. Directed cases from the block's
// behaviour list plus randomized windows compared against an arithmetic model.
module tb_conv_mac_accumulator;

  localparam int DW   = 16;
  localparam int TAPS = 9;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b0;
  logic          relu_en = 1'b0;
  logic [DW-1:0] bias = '0;
  logic [DW-1:0] pix_in = '0;
  logic [DW-1:0] wgt_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    tap_cnt;

  conv_mac_accumulator #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .KERNEL_SIZE(3), .ACC_WIDTH(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .relu_en(relu_en),
    .bias(bias), .pix_in(pix_in), .wgt_in(wgt_in), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .tap_cnt(tap_cnt)
  );

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic signed [DW-1:0] win_pix[TAPS];
  logic signed [DW-1:0] win_wgt[TAPS];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: exact integer sum in Q.8, rescale, clamp, optional ReLU.
  function automatic logic [DW-1:0] model(input logic signed [DW-1:0] b, input bit r);
    longint sum;
    longint s;
    logic [63:0] bits;
    sum = longint'(b) * 256;
    for (int i = 0; i < TAPS; i++) sum += longint'(win_pix[i]) * longint'(win_wgt[i]);
    s = sum >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (r && s < 0) s = 0;
    bits = s;
    return bits[DW-1:0];
  endfunction

  // Driver tasks (all driving and sampling happens at the falling edge)
  task automatic idle_cycle();
    in_valid = 1'b0;
    pix_in = DW'($urandom);
    wgt_in = DW'($urandom);
    @(negedge clk);
  endtask

  task automatic drive_tap(input int idx, input logic [DW-1:0] b, input bit r);
    check_eq("valid_before_tap", out_valid, 0);
    check_eq("tap_cnt_before", tap_cnt, idx);
    pix_in = win_pix[idx];
    wgt_in = win_wgt[idx];
    // bias matters only on the first tap, relu_en only on the last one
    bias = (idx == 0) ? b : DW'($urandom);
    relu_en = (idx == TAPS - 1) ? r : 1'($urandom);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bias = DW'($urandom);
    relu_en = 1'($urandom);
    check_eq("tap_cnt_after", tap_cnt, (idx + 1) % TAPS);
  endtask

  task automatic run_window(input logic [DW-1:0] b, input bit r, input int gap_max, input int ntaps);
    for (int i = 0; i < ntaps; i++) begin
      drive_tap(i, b, r);
      if (i < ntaps - 1) begin
        int g = $urandom_range(0, gap_max);
        for (int k = 0; k < g; k++) idle_cycle();
      end
    end
    if (ntaps == TAPS) exp_q.push_back(model(b, r));
  endtask

  task automatic collect(input int stall, output logic [DW-1:0] obs);
    int n;
    logic [DW-1:0] exp;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("result_latency", n, 0);
    check_eq("out_valid_high", out_valid, 1);
    check_eq("in_ready_low", in_ready, 0);
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 1, 0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    obs = out_data;
    check_eq("out_data", out_data, exp);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      pix_in = DW'($urandom);
      wgt_in = DW'($urandom);
      @(negedge clk);
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, exp);
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_tap_cnt", tap_cnt, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_handshake_valid", out_valid, 0);
    check_eq("post_handshake_in_ready", in_ready, 1);
  endtask

  task automatic fill_const(input logic [DW-1:0] p, input logic [DW-1:0] w);
    for (int i = 0; i < TAPS; i++) begin
      win_pix[i] = p;
      win_wgt[i] = w;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < TAPS; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        win_pix[i] = DW'($urandom_range(0, 1023)) - DW'(512);
        win_wgt[i] = DW'($urandom_range(0, 1023)) - DW'(512);
      end else begin
        win_pix[i] = DW'($urandom);
        win_wgt[i] = DW'($urandom);
      end
    end
  endtask

  logic [DW-1:0] obs;

  initial begin
    // Reset values
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_tap_cnt", tap_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 * 1.0 over nine taps
    fill_const(16'h0100, 16'h0100);
    run_window(16'h0000, 1'b0, 0, TAPS);
    collect(0, obs);
    check_eq("unit_window", obs, 16'h0900);

    // Positive and negative saturation
    fill_const(16'h7FFF, 16'h7FFF);
    run_window(16'h7FFF, 1'b0, 0, TAPS);
    collect(0, obs);
    check_eq("sat_pos", obs, 16'h7FFF);
    fill_const(16'h8000, 16'h7FFF);
    run_window(16'h0000, 1'b0, 0, TAPS);
    collect(0, obs);
    check_eq("sat_neg", obs, 16'h8000);

    // Negative result with and without ReLU
    fill_const(16'h0100, 16'hFF00);
    run_window(16'h0200, 1'b0, 0, TAPS);
    collect(0, obs);
    check_eq("neg_no_relu", obs, 16'hF900);
    run_window(16'h0200, 1'b1, 0, TAPS);
    collect(0, obs);
    check_eq("neg_relu", obs, 16'h0000);

    // Backpressure for five cycles, then a window with a non-zero bias
    fill_random();
    run_window(DW'($urandom), 1'b0, 0, TAPS);
    collect(5, obs);
    fill_random();
    run_window(16'h0300, 1'b0, 0, TAPS);
    collect(0, obs);

    // clear after four taps, then a fresh window
    fill_random();
    run_window(16'h1234, 1'b0, 0, 4);
    clear = 1'b1;
    in_valid = 1'b1;
    pix_in = 16'h0100;
    wgt_in = 16'h0100;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    check_eq("clear_tap_cnt", tap_cnt, 0);
    check_eq("clear_out_valid", out_valid, 0);
    fill_const(16'h0100, 16'h0100);
    run_window(16'h0000, 1'b0, 1, TAPS);
    collect(0, obs);
    check_eq("after_clear", obs, 16'h0900);

    // clear while a result is pending
    fill_random();
    run_window(DW'($urandom), 1'b0, 0, TAPS);
    check_eq("hold_before_clear", out_valid, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_eq("hold_clear_valid", out_valid, 0);
    check_eq("hold_clear_in_ready", in_ready, 1);
    void'(exp_q.pop_front());

    // Reset mid-window
    fill_random();
    run_window(DW'($urandom), 1'b0, 0, 5);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tap_cnt", tap_cnt, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    check_eq("rst_mid_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a non-zero result is held
    fill_const(16'h0100, 16'h0100);
    run_window(16'h0000, 1'b0, 0, TAPS);
    check_eq("hold_before_rst", out_data, 16'h0900);
    rst_n = 1'b0;
    #1;
    check_eq("rst_hold_out_valid", out_valid, 0);
    check_eq("rst_hold_out_data", out_data, 0);
    check_eq("rst_hold_in_ready", in_ready, 1);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized windows with idle gaps and random backpressure
    for (int w = 0; w < 24; w++) begin
      fill_random();
      run_window(DW'($urandom), 1'($urandom), 3, TAPS);
      collect($urandom_range(0, 2), obs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
